filter_cfg_ctrl: RTL
====================

FILTER_CFG_CTRL -- requirements
Module: filter_cfg_ctrl

Interface
REQ-001 Parameter NUM_RULES, default 2, number of filter rules (1..4).
REQ-002 Parameter COMMIT_TIMEOUT, default 4096, cycles a pending commit may wait before pause_req asserts.
REQ-003 aclk  input  1  sole clock; all logic rising-edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 reg_en  input  1  register access strobe, one cycle per access.
REQ-006 reg_we  input  1  1=write, 0=read; qualified by reg_en.
REQ-007 reg_addr  input  12  byte address, word-aligned.
REQ-008 reg_din  input  32  write data.
REQ-009 reg_dout  output  32  read data, valid with reg_rvalid.
REQ-010 reg_rvalid  output  1  read-response strobe.
REQ-011 mon_tvalid, mon_tready, mon_tlast  input  1 each  taps of the filter pipeline's slave AXI-Stream handshake.
REQ-012 cfg_reg  output  cfg_reg_t  active rule set driven to the filter pipeline.
REQ-013 status_reg  input  status_reg_t  hit/total/dropped counters from the filter pipeline.
REQ-014 commit_pending  output  1  shadow commit requested, not yet applied.
REQ-015 pause_req  output  1  request to upstream to withhold the next packet start.

Function
REQ-016 Register map: 0x000 CTRL (write bit0=1 requests commit; reads 0); 0x004 STATUS (bit0 commit_pending, bit1 pause_req); 0x008 COMMIT_COUNT (RO); 0x010/0x014/0x018/0x01C status_reg rule0_hit, rule1_hit, total, dropped (RO).
REQ-017 Rule r shadow at 0x100+r*0x20: +0x00 ipv4_addr, +0x04..+0x10 ipv6_addr bits [31:0],[63:32],[95:64],[127:96], +0x14 port.
REQ-018 Writes update shadow only; cfg_reg changes solely on commit.
REQ-019 Reads return shadow values for rule addresses; unmapped/out-of-range addresses read 0, writes ignored.
REQ-020 Read latency: reg_rvalid and reg_dout one cycle after reg_en&!reg_we; reg_dout holds 0 when reg_rvalid=0.
REQ-021 Packet tracker in_pkt: set on handshake (mon_tvalid&mon_tready) with !mon_tlast; cleared on handshake with mon_tlast.
REQ-022 State machine IDLE -> PENDING on CTRL commit write; PENDING -> APPLY when in_pkt=0 and no handshake this cycle; APPLY -> IDLE after one cycle.
REQ-023 APPLY copies all shadow rules into cfg_reg in one edge, increments COMMIT_COUNT (32-bit, wraps 0xFFFFFFFF->0).
REQ-024 Commit request in PENDING or APPLY merges: no second apply, no extra count; latest shadow contents applied.
REQ-025 Shadow write in the same cycle as APPLY: new value lands in shadow only, applied by the next commit.
REQ-026 commit_pending=1 in PENDING and APPLY.
REQ-027 Wait counter runs in PENDING; pause_req asserts when it reaches COMMIT_TIMEOUT, deasserts on APPLY; counter clears on entering PENDING.
REQ-028 Upstream ignoring pause_req does not break function; commit still waits for a boundary.

Reset
REQ-029 aresetn low: state IDLE, in_pkt=0, shadow and cfg_reg all zero, COMMIT_COUNT=0, wait counter 0, reg_rvalid=0, reg_dout=0, commit_pending=0, pause_req=0.
REQ-030 Reset mid-packet or mid-PENDING discards the pending commit; first beat after release is treated as packet start.

Structure
REQ-031 cfg_reg_t, status_reg_t and register-offset constants live in cfg_reg_pkg; NUM_RULES default matches the package rule array size.
REQ-032 One sub-module, filter_pkt_tracker, implements in_pkt and the boundary-idle indication.

Verification
REQ-033 Write rule0 ipv4=0xC0A80001, no traffic, commit -> cfg_reg rule0 ipv4 = 0xC0A80001 within 2 cycles, COMMIT_COUNT=1.
REQ-034 Commit during 4-beat packet -> cfg_reg unchanged until the cycle after the tlast beat handshake; commit_pending=1 throughout.
REQ-035 Back-to-back packets with no idle cycle, COMMIT_TIMEOUT=16 -> pause_req=1 at 16 pending cycles; commit on first idle cycle; pause_req drops.
REQ-036 Two commits 3 cycles apart while pending, rule1 port changed between -> single apply, COMMIT_COUNT +1, final port value active.
REQ-037 Read 0x014 with status_reg.rule1_hit=0x55 -> reg_rvalid one cycle later, reg_dout=0x55; read 0x7FC -> 0.
REQ-038 Assert aresetn low mid-PENDING and mid-packet -> all outputs zero, commit discarded, COMMIT_COUNT=0.

Source files
------------

// File: rtl/cfg_reg_pkg.sv
// Shared types and register map for the filter configuration controller:
// the rule set driven into the filter pipeline, the counters it reports
// back, the register offsets and the commit state machine encoding.
package cfg_reg_pkg;

    // Number of rule slots physically present in cfg_reg_t.
    localparam int RULE_ARRAY_SIZE = 2;
    localparam int PORT_W          = 16;

    // Control/status register offsets (byte addresses).
    localparam logic [11:0] ADDR_CTRL         = 12'h000;
    localparam logic [11:0] ADDR_STATUS       = 12'h004;
    localparam logic [11:0] ADDR_COMMIT_COUNT = 12'h008;
    localparam logic [11:0] ADDR_RULE0_HIT    = 12'h010;
    localparam logic [11:0] ADDR_RULE1_HIT    = 12'h014;
    localparam logic [11:0] ADDR_TOTAL        = 12'h018;
    localparam logic [11:0] ADDR_DROPPED      = 12'h01C;

    // Rule windows start here, one 32-byte window per rule.
    localparam logic [11:0] RULE_BASE = 12'h100;

    // Word index inside a rule window (address bits [4:2]).
    localparam logic [2:0] RW_IPV4   = 3'd0;
    localparam logic [2:0] RW_IPV6_0 = 3'd1;
    localparam logic [2:0] RW_IPV6_1 = 3'd2;
    localparam logic [2:0] RW_IPV6_2 = 3'd3;
    localparam logic [2:0] RW_IPV6_3 = 3'd4;
    localparam logic [2:0] RW_PORT   = 3'd5;

    typedef struct packed {
        logic [31:0]       ipv4_addr;
        logic [127:0]      ipv6_addr;
        logic [PORT_W-1:0] port;
    } rule_t;

    typedef struct packed {
        rule_t [RULE_ARRAY_SIZE-1:0] rules;
    } cfg_reg_t;

    typedef struct packed {
        logic [31:0] rule0_hit;
        logic [31:0] rule1_hit;
        logic [31:0] total;
        logic [31:0] dropped;
    } status_reg_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } commit_state_t;

    // Select one 32-bit word of a rule as seen through the register window.
    function automatic logic [31:0] rule_word_read(input rule_t rule, input logic [2:0] word);
        logic [31:0] data;
        case (word)
            RW_IPV4:   data = rule.ipv4_addr;
            RW_IPV6_0: data = rule.ipv6_addr[31:0];
            RW_IPV6_1: data = rule.ipv6_addr[63:32];
            RW_IPV6_2: data = rule.ipv6_addr[95:64];
            RW_IPV6_3: data = rule.ipv6_addr[127:96];
            RW_PORT:   data = {{(32-PORT_W){1'b0}}, rule.port};
            default:   data = 32'h0000_0000;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/filter_pkt_tracker.sv
// Tracks whether the filter pipeline's input stream is inside a packet and
// flags cycles that sit on a packet boundary with no beat moving, which are
// the only cycles where the active rule set may be swapped.
module filter_pkt_tracker (
    input  logic aclk,
    input  logic aresetn,
    input  logic mon_tvalid,
    input  logic mon_tready,
    input  logic mon_tlast,
    output logic boundary_idle
);

    logic handshake_s;
    logic in_pkt_r;

    assign handshake_s = mon_tvalid & mon_tready;

    // Packet-in-progress flag: a non-last beat opens a packet, the last beat closes it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_pkt_r <= 1'b0;
        end else if (handshake_s) begin
            in_pkt_r <= ~mon_tlast;
        end else begin
            in_pkt_r <= in_pkt_r;
        end
    end

    assign boundary_idle = ~in_pkt_r & ~handshake_s;

endmodule

// File: rtl/filter_cfg_ctrl.sv
// Filter configuration controller: register-mapped shadow rule set, a commit
// state machine that swaps the shadow into the live rule set only between
// packets, a commit counter and a pause request to upstream when a commit
// has waited too long for a packet boundary.
module filter_cfg_ctrl
    import cfg_reg_pkg::*;
#(
    parameter int NUM_RULES      = RULE_ARRAY_SIZE,
    parameter int COMMIT_TIMEOUT = 4096
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        reg_en,
    input  logic        reg_we,
    input  logic [11:0] reg_addr,
    input  logic [31:0] reg_din,
    output logic [31:0] reg_dout,
    output logic        reg_rvalid,
    input  logic        mon_tvalid,
    input  logic        mon_tready,
    input  logic        mon_tlast,
    output cfg_reg_t    cfg_reg,
    input  status_reg_t status_reg,
    output logic        commit_pending,
    output logic        pause_req
);

    // Rules beyond the physical array have no storage and decode as unmapped.
    localparam int EFF_RULES = (NUM_RULES < RULE_ARRAY_SIZE) ? NUM_RULES : RULE_ARRAY_SIZE;
    localparam logic [2:0] EFF_RULES_L = 3'(EFF_RULES);
    localparam int WAIT_W = (COMMIT_TIMEOUT < 1) ? 1 : $clog2(COMMIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(COMMIT_TIMEOUT);

    commit_state_t     state_r;
    commit_state_t     state_nxt_s;
    logic [WAIT_W-1:0] wait_r;
    logic [WAIT_W-1:0] wait_nxt_s;
    logic              pause_r;
    logic              pause_nxt_s;
    logic              pending_r;
    cfg_reg_t          shadow_r;
    cfg_reg_t          shadow_nxt_s;
    cfg_reg_t          cfg_r;
    logic [31:0]       commit_cnt_r;
    logic              rvalid_r;
    logic [31:0]       dout_r;
    logic [31:0]       read_data_s;
    logic [31:0]       rule_rd_s;
    logic              commit_req_s;
    logic              rule_hit_s;
    logic [1:0]        rule_idx_s;
    logic [2:0]        rule_word_s;
    logic              boundary_idle_s;

    filter_pkt_tracker u_pkt_tracker (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .mon_tvalid    (mon_tvalid),
        .mon_tready    (mon_tready),
        .mon_tlast     (mon_tlast),
        .boundary_idle (boundary_idle_s)
    );

    assign commit_req_s = reg_en & reg_we & (reg_addr == ADDR_CTRL) & reg_din[0];

    // Decode the access address into a rule slot and word, if it hits one.
    always_comb begin
        rule_idx_s  = reg_addr[6:5];
        rule_word_s = reg_addr[4:2];
        if ((reg_addr[11:7] == RULE_BASE[11:7]) && (reg_addr[1:0] == 2'b00) &&
            ({1'b0, rule_idx_s} < EFF_RULES_L) && (rule_word_s <= RW_PORT)) begin
            rule_hit_s = 1'b1;
        end else begin
            rule_hit_s = 1'b0;
        end
    end

    // Next shadow contents: a register write touches only the addressed word.
    always_comb begin
        shadow_nxt_s = shadow_r;
        if (reg_en && reg_we && rule_hit_s) begin
            for (int r = 0; r < RULE_ARRAY_SIZE; r++) begin
                if (rule_idx_s == 2'(r)) begin
                    case (rule_word_s)
                        RW_IPV4:   shadow_nxt_s.rules[r].ipv4_addr         = reg_din;
                        RW_IPV6_0: shadow_nxt_s.rules[r].ipv6_addr[31:0]   = reg_din;
                        RW_IPV6_1: shadow_nxt_s.rules[r].ipv6_addr[63:32]  = reg_din;
                        RW_IPV6_2: shadow_nxt_s.rules[r].ipv6_addr[95:64]  = reg_din;
                        RW_IPV6_3: shadow_nxt_s.rules[r].ipv6_addr[127:96] = reg_din;
                        RW_PORT:   shadow_nxt_s.rules[r].port              = reg_din[PORT_W-1:0];
                        default:   shadow_nxt_s.rules[r]                   = shadow_r.rules[r];
                    endcase
                end else begin
                    shadow_nxt_s.rules[r] = shadow_r.rules[r];
                end
            end
        end else begin
            shadow_nxt_s = shadow_r;
        end
    end

    // Commit state machine: wait for a packet boundary, then apply for one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (commit_req_s) state_nxt_s = ST_PENDING;
                else              state_nxt_s = ST_IDLE;
            end
            ST_PENDING: begin
                if (boundary_idle_s) state_nxt_s = ST_APPLY;
                else                 state_nxt_s = ST_PENDING;
            end
            ST_APPLY: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Wait counter restarts on entry to PENDING and saturates at the timeout.
    always_comb begin
        wait_nxt_s = wait_r;
        if ((state_r == ST_IDLE) && (state_nxt_s == ST_PENDING)) begin
            wait_nxt_s = '0;
        end else if ((state_r == ST_PENDING) && (wait_r < WAIT_LIMIT)) begin
            wait_nxt_s = wait_r + WAIT_W'(1);
        end else if (state_r == ST_PENDING) begin
            wait_nxt_s = wait_r;
        end else begin
            wait_nxt_s = '0;
        end
        pause_nxt_s = (state_nxt_s == ST_PENDING) && (wait_nxt_s >= WAIT_LIMIT);
    end

    // Commit state, wait counter and the status flags derived from them.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r   <= ST_IDLE;
            wait_r    <= '0;
            pause_r   <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            wait_r    <= wait_nxt_s;
            pause_r   <= pause_nxt_s;
            pending_r <= (state_nxt_s != ST_IDLE);
        end
    end

    // Shadow rule storage, written by the register interface.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            shadow_r <= '0;
        end else begin
            shadow_r <= shadow_nxt_s;
        end
    end

    // Live rule set and commit counter, both updated only in APPLY.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_r        <= '0;
            commit_cnt_r <= 32'h0000_0000;
        end else if (state_r == ST_APPLY) begin
            cfg_r        <= shadow_r;
            commit_cnt_r <= commit_cnt_r + 32'h0000_0001;
        end else begin
            cfg_r        <= cfg_r;
            commit_cnt_r <= commit_cnt_r;
        end
    end

    // Read data mux: rule windows first, then the control/status registers.
    always_comb begin
        read_data_s = 32'h0000_0000;
        rule_rd_s   = 32'h0000_0000;
        for (int r = 0; r < RULE_ARRAY_SIZE; r++) begin
            if (rule_idx_s == 2'(r)) rule_rd_s = rule_word_read(shadow_r.rules[r], rule_word_s);
            else                     rule_rd_s = rule_rd_s;
        end
        if (rule_hit_s) begin
            read_data_s = rule_rd_s;
        end else begin
            case (reg_addr)
                ADDR_STATUS:       read_data_s = {30'd0, pause_r, pending_r};
                ADDR_COMMIT_COUNT: read_data_s = commit_cnt_r;
                ADDR_RULE0_HIT:    read_data_s = status_reg.rule0_hit;
                ADDR_RULE1_HIT:    read_data_s = status_reg.rule1_hit;
                ADDR_TOTAL:        read_data_s = status_reg.total;
                ADDR_DROPPED:      read_data_s = status_reg.dropped;
                default:           read_data_s = 32'h0000_0000;
            endcase
        end
    end

    // Registered read response; data is forced to zero outside a response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_r <= 1'b0;
            dout_r   <= 32'h0000_0000;
        end else if (reg_en && !reg_we) begin
            rvalid_r <= 1'b1;
            dout_r   <= read_data_s;
        end else begin
            rvalid_r <= 1'b0;
            dout_r   <= 32'h0000_0000;
        end
    end

    assign cfg_reg        = cfg_r;
    assign commit_pending = pending_r;
    assign pause_req      = pause_r;
    assign reg_rvalid     = rvalid_r;
    assign reg_dout       = dout_r;

endmodule
